inverse_ntt_8: RTL and testbench

//  Iterative 8-point inverse NTT over Z_q, q=3329: exact inverse of the team's pipelined 8-point forward NTT.
//  - Forward convention (CT butterfly): U = a + w*b, V = a - w*b.
//  - Folded design: one Gentleman-Sande butterfly, time-multiplexed over 3 stages x 4 pairs, then a final n^-1 scale pass.
//  - Sits after pointwise multiplication in the Kyber datapath; ready/valid on both sides.

---
 rtl/ntt_pkg.sv | 65 ++++++
 rtl/gs_butterfly.sv | 16 +
 rtl/inverse_ntt_8.sv | 123 ++++++++++++
 tb/tb_inverse_ntt_8.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ntt_pkg.sv
// Shared constants, tables and modular helpers for the q=3329 inverse NTT.
// Twiddle tables are indexed by {stage, pair} = op counter value.
package ntt_pkg;

  localparam int W = 12;
  localparam logic [12:0] Q = 13'd3329;
  localparam logic [11:0] N_INV = 12'd2913;
  localparam logic [12:0] BARRETT_M = 13'd5039;

  typedef logic [W-1:0] coeff_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BFLY,
    S_SCALE,
    S_DONE
  } state_t;

  localparam logic [2:0] INTT_PAIR_J [0:11] = '{
    3'd0, 3'd2, 3'd4, 3'd6,
    3'd0, 3'd1, 3'd4, 3'd5,
    3'd0, 3'd1, 3'd2, 3'd3
  };

  localparam logic [2:0] INTT_PAIR_K [0:11] = '{
    3'd1, 3'd3, 3'd5, 3'd7,
    3'd2, 3'd3, 3'd6, 3'd7,
    3'd4, 3'd5, 3'd6, 3'd7
  };

  localparam coeff_t INTT_TWID [0:11] = '{
    12'd1, 12'd1,    12'd1,    12'd1,
    12'd1, 12'd3289, 12'd1,    12'd3289,
    12'd1, 12'd1600, 12'd3289, 12'd2580
  };

  function automatic coeff_t mod_add(input coeff_t a, input coeff_t b);
    logic [12:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= Q) s = s - Q;
    return coeff_t'(s);
  endfunction

  function automatic coeff_t mod_sub(input coeff_t a, input coeff_t b);
    logic [12:0] s;
    s = {1'b0, a} - {1'b0, b};
    if (s[12]) s = s + Q;
    return coeff_t'(s);
  endfunction

  // Barrett with k=24: estimate is at most one low, so one subtract suffices
  function automatic coeff_t mod_mul_q(input coeff_t a, input coeff_t b);
    logic [23:0] p;
    logic [36:0] pm;
    logic [36:0] qe;
    logic [23:0] r;
    p = 24'(a) * 24'(b);
    pm = 37'(p) * 37'(BARRETT_M);
    qe = pm >> 24;
    r = p - 24'(qe) * 24'(Q);
    if (r >= 24'(Q)) r = r - 24'(Q);
    return coeff_t'(r);
  endfunction

endpackage

// File: rtl/gs_butterfly.sv
// Combinational Gentleman-Sande butterfly over Z_3329.
// u = (a+b) mod Q, v = (a-b)*t mod Q.
module gs_butterfly
  import ntt_pkg::*;
(
  input  coeff_t a,
  input  coeff_t b,
  input  coeff_t t,
  output coeff_t u,
  output coeff_t v
);

  assign u = mod_add(a, b);
  assign v = mod_mul_q(mod_sub(a, b), t);

endmodule

// File: rtl/inverse_ntt_8.sv
// Folded 8-point inverse NTT: one GS butterfly over 12 ops, then n^-1 scaling.
// Ready/valid on both sides; result held in DONE until accepted.
module inverse_ntt_8
  import ntt_pkg::*;
(
  input  logic         clk,
  input  logic         r,
  input  logic         valid_in,
  output logic         ready_in,
  input  coeff_t [7:0] coeffs,
  output logic         valid_out,
  input  logic         ready_out,
  output coeff_t [7:0] coeffs_out,
  output logic         busy
);

  state_t       state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  coeff_t [7:0] regs_q, regs_d;
  coeff_t [7:0] ld;

  logic [2:0] bf_j, bf_k;
  coeff_t     bf_u, bf_v, bf_t, sc_val;
  logic       accept;

  assign bf_j = INTT_PAIR_J[cnt_q];
  assign bf_k = INTT_PAIR_K[cnt_q];
  assign bf_t = INTT_TWID[cnt_q];

  gs_butterfly u_bfly (
    .a (regs_q[bf_j]),
    .b (regs_q[bf_k]),
    .t (bf_t),
    .u (bf_u),
    .v (bf_v)
  );

  assign sc_val = mod_mul_q(regs_q[cnt_q[2:0]], N_INV);

  // Inputs may be up to 2^12-1; one subtract brings them into [0,Q-1]
  always_comb begin
    ld = '0;
    for (int i = 0; i < 8; i++) begin
      if ({1'b0, coeffs[i]} >= Q)
        ld[i] = coeff_t'({1'b0, coeffs[i]} - Q);
      else
        ld[i] = coeffs[i];
    end
  end

  always_comb begin
    ready_in = 1'b0;
    unique case (state_q)
      S_IDLE:  ready_in = 1'b1;
      S_DONE:  ready_in = ready_out;
      default: ready_in = 1'b0;
    endcase
  end

  assign accept     = valid_in & ready_in;
  assign valid_out  = (state_q == S_DONE);
  assign busy       = (state_q == S_BFLY) || (state_q == S_SCALE);
  assign coeffs_out = regs_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    regs_d  = regs_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          regs_d  = ld;
          cnt_d   = 4'd0;
          state_d = S_BFLY;
        end
      end
      S_BFLY: begin
        regs_d[bf_j] = bf_u;
        regs_d[bf_k] = bf_v;
        if (cnt_q == 4'd11) begin
          cnt_d   = 4'd0;
          state_d = S_SCALE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_SCALE: begin
        regs_d[cnt_q[2:0]] = sc_val;
        if (cnt_q == 4'd7) begin
          cnt_d   = 4'd0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_DONE: begin
        if (ready_out) begin
          if (valid_in) begin
            regs_d  = ld;
            cnt_d   = 4'd0;
            state_d = S_BFLY;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      regs_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      regs_q  <= regs_d;
    end
  end

endmodule

// File: tb/tb_inverse_ntt_8.sv
// Bench for inverse_ntt_8: scoreboard of expected time-domain vectors,
// stimulus built from an independent forward-NTT model.
module tb_inverse_ntt_8;

  typedef logic [7:0][11:0] vec_t;

  logic clk = 1'b0;
  logic r;
  logic valid_in;
  logic ready_in;
  vec_t coeffs;
  logic valid_out;
  logic ready_out;
  vec_t coeffs_out;
  logic busy;

  int checks = 0;
  int errors = 0;
  vec_t exp_q[$];

  always #5 clk = ~clk;

  inverse_ntt_8 dut (
    .clk        (clk),
    .r          (r),
    .valid_in   (valid_in),
    .ready_in   (ready_in),
    .coeffs     (coeffs),
    .valid_out  (valid_out),
    .ready_out  (ready_out),
    .coeffs_out (coeffs_out),
    .busy       (busy)
  );

  function automatic int mm(input int a, input int b);
    return (a * b) % 3329;
  endfunction

  // Forward CT NTT: distance 4, then 2, then 1; U=a+wb, V=a-wb
  function automatic vec_t fwd(input vec_t x);
    int a[8];
    int w4[4] = '{1, 1729, 749, 40};
    int w2[4] = '{1, 749, 1, 749};
    int j2[4] = '{0, 1, 4, 5};
    int t, u, j, k;
    vec_t y;
    for (int i = 0; i < 8; i++) a[i] = int'(x[i]);
    for (int p = 0; p < 4; p++) begin
      j = p; k = p + 4;
      t = mm(w4[p], a[k]);
      u = (a[j] + t) % 3329;
      a[k] = (a[j] - t + 3329) % 3329;
      a[j] = u;
    end
    for (int p = 0; p < 4; p++) begin
      j = j2[p]; k = j + 2;
      t = mm(w2[p], a[k]);
      u = (a[j] + t) % 3329;
      a[k] = (a[j] - t + 3329) % 3329;
      a[j] = u;
    end
    for (int p = 0; p < 4; p++) begin
      j = 2 * p; k = j + 1;
      t = a[k];
      u = (a[j] + t) % 3329;
      a[k] = (a[j] - t + 3329) % 3329;
      a[j] = u;
    end
    for (int i = 0; i < 8; i++) y[i] = 12'(a[i]);
    return y;
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    for (int i = 0; i < 8; i++) v[i] = 12'($urandom_range(0, 3328));
    return v;
  endfunction

  function automatic vec_t impulse(input int val);
    vec_t v;
    v = '0;
    v[0] = 12'(val);
    return v;
  endfunction

  // Present v until accepted; returns #1 after the accept edge
  task automatic drive(input vec_t v);
    int g;
    g = 0;
    while (!ready_in && g < 200) begin
      @(posedge clk); #1;
      g++;
    end
    valid_in = 1'b1;
    coeffs   = v;
    @(posedge clk); #1;
    valid_in = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!valid_out && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic test_reset();
    r = 1'b0;
    valid_in = 1'b0;
    ready_out = 1'b1;
    coeffs = '0;
    #12;
    checks++;
    if ({valid_out, busy, ready_in} !== 3'b001) begin
      errors++;
      $display("FAIL reset_ctrl got v/b/r=%b want 001", {valid_out, busy, ready_in});
    end
    checks++;
    if (coeffs_out !== '0) begin
      errors++;
      $display("FAIL reset_data got %h want 0", coeffs_out);
    end
    @(posedge clk); #1;
    r = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_impulse();
    int n;
    vec_t e;
    exp_q.push_back(impulse(1));
    drive({8{12'd1}});
    wait_valid(n);
    checks++;
    if (n !== 20) begin
      errors++;
      $display("FAIL ones_latency got %0d want 20", n);
    end
    e = exp_q.pop_front();
    checks++;
    if (coeffs_out !== e) begin
      errors++;
      $display("FAIL ones_data got %h want %h", coeffs_out, e);
    end
    @(posedge clk); #1;
    checks++;
    if ({valid_out, ready_in} !== 2'b01) begin
      errors++;
      $display("FAIL ones_release got v/r=%b want 01", {valid_out, ready_in});
    end
  endtask

  task automatic test_boundary();
    int n;
    vec_t e;
    vec_t ins[2];
    int outs[2] = '{3328, 766};
    ins[0] = {8{12'd3328}};
    ins[1] = {8{12'd4095}};
    for (int c = 0; c < 2; c++) begin
      exp_q.push_back(impulse(outs[c]));
      drive(ins[c]);
      wait_valid(n);
      e = exp_q.pop_front();
      checks++;
      if (valid_out !== 1'b1 || coeffs_out !== e) begin
        errors++;
        $display("FAIL boundary%0d got v=%b %h want %h", c, valid_out, coeffs_out, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_roundtrip();
    int n;
    vec_t x, e;
    for (int it = 0; it < 1000; it++) begin
      x = rand_vec();
      exp_q.push_back(x);
      drive(fwd(x));
      wait_valid(n);
      e = exp_q.pop_front();
      checks++;
      if (n !== 20) begin
        errors++;
        $display("FAIL rt_latency it=%0d got %0d want 20", it, n);
      end
      checks++;
      if (coeffs_out !== e) begin
        errors++;
        $display("FAIL rt_data it=%0d got %h want %h", it, coeffs_out, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    int n;
    vec_t x, e;
    x = rand_vec();
    ready_out = 1'b0;
    exp_q.push_back(x);
    drive(fwd(x));
    for (int c = 0; c < 5; c++) begin
      valid_in = 1'b1;
      coeffs = rand_vec();
      @(posedge clk); #1;
      checks++;
      if ({busy, ready_in} !== 2'b10) begin
        errors++;
        $display("FAIL bp_busy c=%0d got b/r=%b want 10", c, {busy, ready_in});
      end
    end
    valid_in = 1'b0;
    wait_valid(n);
    e = exp_q.pop_front();
    for (int c = 0; c < 10; c++) begin
      valid_in = c[0];
      coeffs = rand_vec();
      checks++;
      if (valid_out !== 1'b1 || ready_in !== 1'b0 || coeffs_out !== e) begin
        errors++;
        $display("FAIL bp_hold c=%0d got v=%b r=%b %h want %h",
                 c, valid_out, ready_in, coeffs_out, e);
      end
      @(posedge clk); #1;
    end
    valid_in = 1'b0;
    ready_out = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({valid_out, busy, ready_in} !== 3'b001) begin
      errors++;
      $display("FAIL bp_release got v/b/r=%b want 001", {valid_out, busy, ready_in});
    end
  endtask

  task automatic test_back_to_back();
    int n;
    vec_t x1, x2, e;
    x1 = rand_vec();
    x2 = rand_vec();
    exp_q.push_back(x1);
    drive(fwd(x1));
    wait_valid(n);
    e = exp_q.pop_front();
    checks++;
    if (coeffs_out !== e) begin
      errors++;
      $display("FAIL b2b_first got %h want %h", coeffs_out, e);
    end
    exp_q.push_back(x2);
    valid_in = 1'b1;
    coeffs = fwd(x2);
    checks++;
    if (ready_in !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ready got %b want 1", ready_in);
    end
    @(posedge clk); #1;
    valid_in = 1'b0;
    checks++;
    if ({valid_out, busy} !== 2'b01) begin
      errors++;
      $display("FAIL b2b_reload got v/b=%b want 01", {valid_out, busy});
    end
    wait_valid(n);
    checks++;
    if (n !== 20) begin
      errors++;
      $display("FAIL b2b_latency got %0d want 20", n);
    end
    e = exp_q.pop_front();
    checks++;
    if (coeffs_out !== e) begin
      errors++;
      $display("FAIL b2b_second got %h want %h", coeffs_out, e);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_abort();
    int n;
    vec_t e;
    drive({8{12'd1}});
    repeat (7) begin
      @(posedge clk); #1;
    end
    r = 1'b0;
    #1;
    checks++;
    if ({valid_out, busy, ready_in} !== 3'b001 || coeffs_out !== '0) begin
      errors++;
      $display("FAIL abort_now got v/b/r=%b %h want 001 0",
               {valid_out, busy, ready_in}, coeffs_out);
    end
    @(posedge clk); #1;
    r = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({valid_out, busy} !== 2'b00) begin
      errors++;
      $display("FAIL abort_idle got v/b=%b want 00", {valid_out, busy});
    end
    exp_q.push_back(impulse(1));
    drive({8{12'd1}});
    wait_valid(n);
    e = exp_q.pop_front();
    checks++;
    if (n !== 20 || coeffs_out !== e) begin
      errors++;
      $display("FAIL abort_rerun got n=%0d %h want 20 %h", n, coeffs_out, e);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_impulse();
    test_boundary();
    test_backpressure();
    test_back_to_back();
    test_abort();
    test_roundtrip();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
